tick_arbiter: RTL and testbench

Shares one programmable clock-enable divider between NREQ requesters (display serial link, UART, slow peripheral pollers) so that only one divide counter exists in the fabric. A requester presents a divisor and a tick count. The block grants the divider round-robin, emits exactly that many single-cycle `tick` enables at the requested rate, then releases the divider. It sits between the system `clk` domain and the slow serial engines, replacing per-engine free-running dividers.

---
 rtl/tick_arbiter.sv | 132 +++++++++++++
 tb/tb_tick_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/tick_arbiter.sv
// rtl/tick_arbiter.sv - round-robin owner of one shared clock-enable divider
// Optional square-wave output built only when TICK_ARBITER_SQWAVE_EN is defined.
module tick_arbiter #(
  parameter int NREQ  = 2,
  parameter int DIV_W = 8,
  parameter int LEN_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DIV_W-1:0]  div_i,
  input  logic [NREQ*LEN_W-1:0]  len_i,
  output logic [NREQ-1:0]        gnt,
  output logic                   tick,
  output logic                   done,
  output logic                   busy,
  output logic                   sq_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    last_q, last_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] rem_q, rem_d;

  logic             found;
  logic [IW-1:0]    win;
  logic [IW-1:0]    cand;
  logic             active;
  logic             abort;
  logic             hit;

  // Search starts one past the previous winner so a re-requesting owner goes last.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    cand  = last_q;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(last_q) + i) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign active = (state_q == S_LOAD) || (state_q == S_RUN);
  assign abort  = active && !req[last_q];
  assign hit    = (cnt_q == div_q);

  assign tick = (state_q == S_RUN) && !abort && hit;
  assign done = (state_q == S_DONE);
  assign busy = (state_q != S_IDLE);
  assign gnt  = active ? (NREQ'(1) << last_q) : '0;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    div_d   = div_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          last_d  = win;
          div_d   = div_i[int'(win)*DIV_W +: DIV_W];
          rem_d   = len_i[int'(win)*LEN_W +: LEN_W];
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d = '0;
        if (abort)               state_d = S_IDLE;
        else if (rem_q == '0)    state_d = S_DONE;
        else                     state_d = S_RUN;
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (hit) begin
          cnt_d = '0;
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= IW'(NREQ - 1);
      div_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef TICK_ARBITER_SQWAVE_EN
  logic sq_q, sq_d;

  // Only holds its phase while staying in RUN; any other next state parks it low.
  always_comb begin
    sq_d = 1'b0;
    if (state_d == S_RUN) sq_d = sq_q ^ tick;
  end

  always_ff @(posedge clk) begin
    if (rst) sq_q <= 1'b0;
    else     sq_q <= sq_d;
  end

  assign sq_o = sq_q;
`else
  assign sq_o = 1'b0;
`endif

endmodule

// File: tb/tb_tick_arbiter.sv
// tb/tb_tick_arbiter.sv - directed self-checking bench for tick_arbiter
module tb_tick_arbiter;

  localparam int NREQ  = 2;
  localparam int DIV_W = 8;
  localparam int LEN_W = 16;
  localparam int HMAX  = 300;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [DIV_W-1:0]      div0, div1;
  logic [LEN_W-1:0]      len0, len1;
  logic [NREQ-1:0]       gnt;
  logic                  tick, done, busy, sq_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [HMAX-1:0] tick_v, done_v, busy_v, sq_v;
  logic [NREQ-1:0] gnt_h [0:HMAX-1];
  int ntick, n_overlap, n_badgnt;

  tick_arbiter #(.NREQ(NREQ), .DIV_W(DIV_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .div_i ({div1, div0}),
    .len_i ({len1, len0}),
    .gnt   (gnt),
    .tick  (tick),
    .done  (done),
    .busy  (busy),
    .sq_o  (sq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle c of the history is the state seen just after the c-th edge.
  task automatic observe(input int ncyc, input bit drop_on_done, input int abort_after);
    int abort_at;
    abort_at  = -1;
    tick_v    = '0;
    done_v    = '0;
    busy_v    = '0;
    sq_v      = '0;
    ntick     = 0;
    n_overlap = 0;
    n_badgnt  = 0;
    for (int c = 0; c < HMAX; c++) gnt_h[c] = '0;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      tick_v[c] = tick;
      done_v[c] = done;
      busy_v[c] = busy;
      sq_v[c]   = sq_o;
      gnt_h[c]  = gnt;
      if (tick && done) n_overlap++;
      if ((gnt != '0) && (done || !busy || $countones(gnt) > 1)) n_badgnt++;
      if (tick) begin
        ntick++;
        if (abort_after > 0 && ntick == abort_after) abort_at = c + 1;
      end
      if (c == abort_at) req = '0;
      if (done && drop_on_done) req = '0;
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    div0 = '0; div1 = '0;
    len0 = '0; len1 = '0;
    step();
    step();
    rst = 1'b0;
    check("reset_outputs", {gnt, tick, done, busy, sq_o}, '0);

    // Single burst: div 80, len 3 on requester 0
    div0 = 8'd80; len0 = 16'd3; req = 2'b01;
    observe(250, 1'b1, 0);
    check("single_gnt_t1",   gnt_h[1], 2'b01);
    check("single_busy_t1",  busy_v[1], 1'b1);
    check("single_tick_cnt", ntick, 3);
    check("single_ticks",    {tick_v[82], tick_v[163], tick_v[244]}, 3'b111);
    check("single_done",     {done_v[245], done_v[244], done_v[246]}, 3'b100);
    check("single_gnt_T1",   gnt_h[245], 2'b00);
    check("single_busy_end", {busy_v[245], busy_v[246]}, 2'b10);
    check("single_overlap",  n_overlap, 0);
    check("single_badgnt",   n_badgnt, 0);

    // Round robin: both requesting, div 0, len 2
    rst = 1'b1; step(); rst = 1'b0;
    div0 = 8'd0; div1 = 8'd0; len0 = 16'd2; len1 = 16'd2; req = 2'b11;
    observe(14, 1'b0, 0);
    req = '0;
    check("rr_gnt_1",   gnt_h[1],  2'b01);
    check("rr_gnt_6",   gnt_h[6],  2'b10);
    check("rr_gnt_11",  gnt_h[11], 2'b01);
    check("rr_ticks",   tick_v[15:0], 16'd12684);
    check("rr_dones",   done_v[15:0], 16'd16912);
    check("rr_overlap", n_overlap, 0);
    check("rr_badgnt",  n_badgnt, 0);
    step(); step();

    // Zero length on requester 0
    div0 = 8'd5; len0 = 16'd0; req = 2'b01;
    observe(5, 1'b1, 0);
    check("zero_gnt",   {gnt_h[1], gnt_h[2]}, 4'b0100);
    check("zero_done",  done_v[5:0], 6'b000100);
    check("zero_ticks", ntick, 0);
    check("zero_busy",  busy_v[5:0], 6'b000110);

    // Abort: requester 1, div 10, len 5, drops after second tick
    div1 = 8'd10; len1 = 16'd5; req = 2'b10;
    observe(40, 1'b1, 2);
    check("abort_ticks",     ntick, 2);
    check("abort_tick_pos",  {tick_v[12], tick_v[23]}, 2'b11);
    check("abort_gnt",       {gnt_h[24], gnt_h[25]}, 4'b1000);
    check("abort_busy",      busy_v[25], 1'b0);
    check("abort_no_done",   $countones(done_v), 0);

    // Reset mid-RUN, then simultaneous request goes to requester 0
    div0 = 8'd10; len0 = 16'd5; req = 2'b01;
    observe(5, 1'b1, 0);
    check("pre_reset_busy", {busy_v[5], gnt_h[5]}, 3'b101);
    rst = 1'b1;
    step();
    check("midrun_reset_out", {gnt, tick, done, busy, sq_o}, '0);
    rst = 1'b0;
    req = 2'b11;
    step();
    check("post_reset_gnt", gnt, 2'b01);
    req = '0;
    step(); step();
    check("post_abort_idle", {gnt, busy}, 3'b000);

    // Square wave: div 2, len 4
    rst = 1'b1; step(); rst = 1'b0;
    div0 = 8'd2; len0 = 16'd4; req = 2'b01;
    observe(20, 1'b1, 0);
    check("sq_ticks", tick_v[19:0], 20'd9360);
    check("sq_done",  done_v[19:0], 20'd16384);
`ifdef TICK_ARBITER_SQWAVE_EN
    check("sq_wave",  sq_v[19:0], 20'd14560);
`else
    check("sq_tied",  sq_v[19:0], 20'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
